// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit engine, one bit per clk cycle (clk = baud clock).
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// Parity encoding matches the RX checker: PAR_TYP 0 = even, 1 = odd.
// Build option: define UART_TX_TWO_STOP_EN to send two stop bits per frame.
// TX_OUT and Busy are driven directly from flops; DATA_WIDTH is meant for 5..8.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
    ST_STOP   = 3'd4,
    ST_STOP2  = 3'd5
`else
    ST_STOP   = 3'd4
`endif
  } state_t;

  // Parity bit for the frame: even makes the total count of ones even,
  // odd makes it odd, so the odd case is the even bit inverted.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                      input logic                  odd);
    return (^data) ^ odd;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_inc_s;

  // Next-state logic; tx_d/busy_d describe the line during the state being entered,
  // so the outputs register in step with the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    cnt_inc_s = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          // Capture the whole request; the parity bit is fixed here so later
          // input changes cannot disturb the frame in flight.
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = parity_bit(P_DATA, PAR_TYP);
          cnt_d     = '0;
          state_d   = ST_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
        busy_d  = 1'b1;
      end

      ST_DATA: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          cnt_d = '0;
          if (par_en_q) begin
            state_d = ST_PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d   = cnt_inc_s;
          state_d = ST_DATA;
          tx_d    = data_q[cnt_inc_s];
        end
      end

      ST_PARITY: begin
        state_d = ST_STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end

`ifdef UART_TX_TWO_STOP_EN
      ST_STOP: begin
        state_d = ST_STOP2;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end

      ST_STOP2: begin
        // Always pass through IDLE so held requests get one mark cycle between frames.
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
`else
      ST_STOP: begin
        // Always pass through IDLE so held requests get one mark cycle between frames.
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
`endif

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, latches and registered outputs; synchronous active-low reset abandons any frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed and randomized frames checked cycle by cycle
// against a queue-based frame model built from the UART framing rules.
module tb_uart_tx_frame;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          Busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input logic obs, input logic exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line levels for one frame, in transmission order.
  function automatic void build_frame(input logic [DW-1:0] d, input bit pen, input bit ptyp);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    ones = $countones(d);
    if (pen) begin
      if (!ptyp) exp_q.push_back((ones % 2) == 1);
      else       exp_q.push_back((ones % 2) == 0);
    end
    exp_q.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
    exp_q.push_back(1'b1);
`endif
  endfunction

  // Request a frame from IDLE and check every cycle of it plus the idle gap.
  task automatic send_frame(input logic [DW-1:0] d, input bit pen, input bit ptyp,
                            input bit noise, input bit hold, input string tag);
    int n;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    build_frame(d, pen, ptyp);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      check(TX_OUT, exp_q[i], $sformatf("%s_tx%0d", tag, i));
      check(Busy, 1'b1, $sformatf("%s_busy%0d", tag, i));
      Data_Valid = hold;
      if (noise && i < n - 1) begin
        P_DATA     = (i % 2 == 0) ? '1 : DW'($urandom);
        PAR_EN     = 1'($urandom_range(0, 1));
        PAR_TYP    = 1'($urandom_range(0, 1));
        Data_Valid = 1'b1;
      end
    end
    tick();
    check(TX_OUT, 1'b1, {tag, "_idle_tx"});
    check(Busy, 1'b0, {tag, "_idle_busy"});
    if (!hold) begin
      tick();
      check(TX_OUT, 1'b1, {tag, "_idle2_tx"});
      check(Busy, 1'b0, {tag, "_idle2_busy"});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    bit pen, ptyp, noise, hold;

    // Reset held with a pending request: line stays idle.
    reset      = 1'b0;
    Data_Valid = 1'b1;
    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check(TX_OUT, 1'b1, "reset_tx");
      check(Busy, 1'b0, "reset_busy");
    end
    reset = 1'b1;

    // Directed frames.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "even_a5");
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, "odd_01");
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, "nopar_01");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, "ignore_3c");
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, "ignore_c3");

    // Data_Valid held high: one idle cycle between consecutive frames.
    send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b1, "hold0");
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, "hold1");
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, "hold2");

    // Reset while data bit 4 is on the line.
    P_DATA     = 8'h5A;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    build_frame(8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check(TX_OUT, exp_q[i], $sformatf("midrst_tx%0d", i));
      check(Busy, 1'b1, $sformatf("midrst_busy%0d", i));
      Data_Valid = 1'b0;
    end
    reset = 1'b0;
    tick();
    check(TX_OUT, 1'b1, "midrst_abort_tx");
    check(Busy, 1'b0, "midrst_abort_busy");
    reset = 1'b1;
    tick();
    check(TX_OUT, 1'b1, "midrst_after_tx");
    check(Busy, 1'b0, "midrst_after_busy");
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, "midrst_new");

    // Randomized frames, some with mid-frame input noise, some back-to-back.
    for (int k = 0; k < 24; k++) begin
      d     = DW'($urandom);
      pen   = 1'($urandom_range(0, 1));
      ptyp  = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      hold  = (k < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      send_frame(d, pen, ptyp, noise, hold, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit engine: the transmit-side counterpart of the UART RX datapath (parity check, deserialiser).
- Accepts a parallel byte with a valid strobe.
- Serialises it as start + data (LSB first) + optional parity + stop, one bit per clk cycle; clk runs at the TX baud rate.
- Parity generation uses the same PAR_EN/PAR_TYP encoding that the RX parity checker expects, so TX and RX interoperate directly.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (valid range 5..8); sets P_DATA width and bit-counter range.

Ports:
- clk  input  1  TX baud clock; all state updates on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clk
- P_DATA  input  DATA_WIDTH  parallel data to transmit
- Data_Valid  input  1  request strobe; sampled only in IDLE
- PAR_EN  input  1  1 = parity bit inserted after data
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- TX_OUT  output  1  serial line, registered, idle/mark = 1
- Busy  output  1  registered; 1 while a frame is on the line

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, TX_OUT=1, Busy=0, bit counter=0, data/config latches cleared. Applies mid-frame too; the frame is abandoned with no partial stop bit. The line returns to 1 on that edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - If Data_Valid=1 at an edge: latch P_DATA, PAR_EN and PAR_TYP, compute parity from the latched data, then go to START.
- Latency: Data_Valid high at edge n gives TX_OUT=0 and Busy=1 after edge n (visible cycle n+1).
- START: TX_OUT=0 for 1 cycle, then DATA with counter=0.
- DATA:
  - TX_OUT=data[counter], LSB first, 1 cycle per bit.
  - Counter increments each cycle.
  - After bit DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else STOP. Counter clears to 0.
- PARITY: TX_OUT = ^data when PAR_TYP=0 (even), ~^data when PAR_TYP=1 (odd); 1 cycle; then STOP.
- STOP: TX_OUT=1, Busy=1 for 1 cycle, then IDLE.
- Frame length (cycles with Busy=1): 1 + DATA_WIDTH + PAR_EN + stop bits. Default build is 10 without parity, 11 with parity.
- Data_Valid, P_DATA, PAR_EN and PAR_TYP are ignored while Busy=1. Requests made during a frame are dropped, not queued. Input changes mid-frame do not affect the frame in flight.
- Back-to-back: if Data_Valid is held high, each new frame starts after exactly one IDLE cycle (TX_OUT=1) following STOP.
- TX_OUT and Busy come straight from flops, with no combinational path from any input.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 cycles (TX_OUT=1, Busy=1 for both), implemented as a STOP2 state or a stop counter. Frame length increases by 1 cycle.
- Undefined: single stop bit exactly as above, with no extra state or counter logic.

Test Plan:
- Reset: hold reset=0 for 3 cycles with Data_Valid=1 → TX_OUT=1, Busy=0 throughout. The first Data_Valid after release starts a frame on the next cycle.
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Data_Valid pulse → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB first, parity=0, stop). Busy=1 for exactly 11 cycles.
- Odd parity / no parity:
  - P_DATA=0x01, PAR_EN=1, PAR_TYP=1 → parity bit=0, 11-cycle frame.
  - Same data with PAR_EN=0 → 0,1,0,0,0,0,0,0,0,1 and Busy=1 for 10 cycles.
- Ignore while busy:
  - Start 0x3C, then change P_DATA to 0xFF and pulse Data_Valid during DATA → transmitted bits remain 0x3C and no second frame follows.
  - Holding Data_Valid high continuously → frames separated by exactly one idle-1 cycle.
- Reset mid-frame: assert reset=0 during data bit 4 → on the next edge TX_OUT=1, Busy=0, state IDLE. A new request afterwards transmits a full correct frame.
- With UART_TX_TWO_STOP_EN defined: 0xA5, PAR_EN=1 → 12-cycle frame ending in 1,1, followed by an idle cycle before the next start.
